mem_backend_model: RTL and testbench

Parametrised behavioural memory backend for simulation, serving the `main_memory` master-side interface with configurable data width, depth and read latency. It supports true burst reads and writes under a `mem_busy` handshake, with optional pseudo-random stall injection. It sits under the memory controller in testbenches and replaces the fixed 32-bit, zero-wait-state backend model.

---
 rtl/mem_backend_model_if.sv | 26 ++
 rtl/mem_backend_model.sv | 168 ++++++++++++++++
 tb/tb_mem_backend_model.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_backend_model_if.sv
// Master/slave bundle for the main_memory port served by mem_backend_model.
// The master (memory controller or bench) drives commands; the slave returns busy and read data.
`timescale 1ns/1ps
interface mem_backend_model_if #(
  parameter int DATA_W = 32
);
  logic [31:0]         mem_addr;
  logic [DATA_W-1:0]   mem_din;
  logic [DATA_W/8-1:0] mem_be;
  logic [7:0]          mem_burstcount;
  logic                mem_rd;
  logic                mem_we;
  logic                mem_busy;
  logic [DATA_W-1:0]   mem_dout;
  logic                mem_dout_ready;

  modport master (
    output mem_addr, mem_din, mem_be, mem_burstcount, mem_rd, mem_we,
    input  mem_busy, mem_dout, mem_dout_ready
  );

  modport slave (
    input  mem_addr, mem_din, mem_be, mem_burstcount, mem_rd, mem_we,
    output mem_busy, mem_dout, mem_dout_ready
  );
endinterface

// File: rtl/mem_backend_model.sv
// Behavioural burst memory backend with configurable width, depth and read latency.
// Define MEM_BACKEND_STALL_EN to inject LFSR-driven stalls on command, write and read-issue cycles.
`timescale 1ns/1ps
module mem_backend_model #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1 << 20,
  parameter int RD_LATENCY  = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_backend_model_if.slave mem
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  generate
    if (!(DATA_W == 32 || DATA_W == 64) || DEPTH_WORDS < 2 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 ||
        RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_params
      $error("mem_backend_model: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_BURST = 2'd1,
    S_WR_BURST = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         rem_q, rem_d;
  logic [DATA_W-1:0]  ram [DEPTH_WORDS];

  logic               stall;
  logic [IDX_W-1:0]   addr_idx;
  logic [7:0]         cnt_eff;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               iss_vld;
  logic [DATA_W-1:0]  iss_data;

  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY-1:0] in_vld;
  logic [DATA_W-1:0]     in_dat [RD_LATENCY];
  logic [DATA_W-1:0]     dat_q  [RD_LATENCY];
  logic                  seen_q;

  // Address bits outside the word index are intentionally don't-care.
  logic unused_addr;
  assign unused_addr = ^mem.mem_addr;

  assign addr_idx = mem.mem_addr[OFFS +: IDX_W];
  assign cnt_eff  = (mem.mem_burstcount == 8'd0) ? 8'd1 : mem.mem_burstcount;
  assign iss_data = ram[idx_q];

`ifdef MEM_BACKEND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign stall  = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    wr_en   = 1'b0;
    wr_idx  = addr_idx;
    iss_vld = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem.mem_we && !stall) begin
          wr_en   = 1'b1;
          wr_idx  = addr_idx;
          idx_d   = addr_idx;
          rem_d   = cnt_eff - 8'd1;
          if (cnt_eff > 8'd1) state_d = S_WR_BURST;
        end else if (mem.mem_rd && !stall) begin
          idx_d   = addr_idx;
          rem_d   = cnt_eff;
          state_d = S_RD_BURST;
        end
      end
      S_RD_BURST: begin
        if (!stall) begin
          iss_vld = 1'b1;
          idx_d   = idx_q + 1'b1;
          rem_d   = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_IDLE;
        end
      end
      S_WR_BURST: begin
        if (mem.mem_we && !stall) begin
          wr_en  = 1'b1;
          wr_idx = idx_q + 1'b1;
          idx_d  = idx_q + 1'b1;
          rem_d  = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end

  // Byte-merged write; contents survive reset, and no write lands while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem.mem_be[b]) ram[wr_idx][b*8 +: 8] <= mem.mem_din[b*8 +: 8];
      end
    end
  end

  // Stage boundary: read-latency pipe, stage 0 loads on beat issue.
  always_comb begin
    in_vld[0] = iss_vld;
    in_dat[0] = iss_data;
    for (int i = 1; i < RD_LATENCY; i++) begin
      in_vld[i] = vld_q[i-1];
      in_dat[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      vld_q  <= in_vld;
      if (in_vld[RD_LATENCY-1]) seen_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (in_vld[i]) dat_q[i] <= in_dat[i];
    end
  end

  // Output stage holds its last beat; it reads as zero until a beat lands after reset.
  assign mem.mem_dout       = seen_q ? dat_q[RD_LATENCY-1] : '0;
  assign mem.mem_dout_ready = vld_q[RD_LATENCY-1];
  assign mem.mem_busy       = (state_q == S_RD_BURST) | stall;

endmodule

// File: tb/tb_mem_backend_model.sv
// Randomised bench for mem_backend_model against a word-array model with a timed beat scoreboard.
`timescale 1ns/1ps
module tb_mem_backend_model;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LAT    = 3;
  localparam int BYTES  = DATA_W / 8;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_backend_model_if #(.DATA_W(DATA_W)) mif ();

  mem_backend_model #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH),
    .RD_LATENCY  (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (mif)
  );

  always #5 clk = ~clk;

  int          n_vec      = 0;
  int          n_err      = 0;
  int          cyc        = 0;
  int          beats_seen = 0;
  logic [31:0] mem_m [DEPTH];
  beat_t       exp_q [$];
  logic [31:0] last_dout  = 32'h0;
  logic [15:0] lfsr_m;
  logic        stall_exp;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= lfsr_next(lfsr_m);
  end

`ifdef MEM_BACKEND_STALL_EN
  assign stall_exp = (lfsr_m[1:0] == 2'b00);
`else
  assign stall_exp = 1'b0;
`endif

  // Beat scoreboard: every cycle either a due beat arrives or dout holds.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      last_dout = 32'h0;
    end else if (mif.mem_dout_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_beat: cyc=%0d dout=%h, required no beat", cyc, mif.mem_dout);
      end else begin
        e = exp_q.pop_front();
        if (mif.mem_dout !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL beat: dout=%h at cyc %0d, required %h at cyc %0d",
                   mif.mem_dout, cyc, e.data, e.cyc);
        end
      end
      beats_seen++;
      last_dout = mif.mem_dout;
    end else begin
      n_vec++;
      if (mif.mem_dout !== last_dout) begin
        n_err++;
        $display("FAIL dout_hold: dout=%h, required %h", mif.mem_dout, last_dout);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_err++;
        $display("FAIL missed_beat: ready=%b at cyc %0d, required beat %h", mif.mem_dout_ready, cyc, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mif.mem_we = 1'b0;
      mif.mem_rd = 1'b0;
      n_vec++;
      if (mif.mem_busy !== stall_exp) begin
        n_err++;
        $display("FAIL idle_busy: busy=%b, required %b", mif.mem_busy, stall_exp);
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 60 && exp_q.size() > 0; t++) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Waits in front of an IDLE-state accept; returns with the accepting edge still ahead.
  task automatic wait_accept(input string what);
    int t;
    for (t = 0; t < 100; t++) begin
      n_vec++;
      if (mif.mem_busy !== stall_exp) begin
        n_err++;
        $display("FAIL %s_busy: busy=%b, required %b", what, mif.mem_busy, stall_exp);
      end
      if (!stall_exp) break;
      @(negedge clk);
    end
    if (t == 100) begin
      n_err++;
      $display("FAIL %s_timeout: busy=%b, required accept within 100 cycles", what, mif.mem_busy);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int bc, input logic [31:0] d [8],
                          input logic [3:0] b [8], input int maxgap, input logic rd0);
    int n, idx;
    n   = (bc == 0) ? 1 : bc;
    idx = int'(addr >> 2) % DEPTH;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        repeat ($urandom_range(0, maxgap)) begin
          @(negedge clk);
          mif.mem_we = 1'b0;
          mif.mem_rd = 1'($urandom);
          n_vec++;
          if (mif.mem_busy !== stall_exp) begin
            n_err++;
            $display("FAIL wr_gap_busy: busy=%b, required %b", mif.mem_busy, stall_exp);
          end
        end
      end
      @(negedge clk);
      mif.mem_we         = 1'b1;
      mif.mem_rd         = (k == 0) ? rd0 : 1'($urandom);
      mif.mem_addr       = (k == 0) ? addr : $urandom;
      mif.mem_burstcount = 8'(bc);
      mif.mem_din        = d[k];
      mif.mem_be         = b[k];
      wait_accept("wr_beat");
      for (int i = 0; i < BYTES; i++)
        if (b[k][i]) mem_m[idx][i*8 +: 8] = d[k][i*8 +: 8];
      idx = (idx + 1) % DEPTH;
    end
    @(negedge clk);
    mif.mem_we = 1'b0;
    mif.mem_rd = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int bc);
    int n, idx, k, t;
    n   = (bc == 0) ? 1 : bc;
    idx = int'(addr >> 2) % DEPTH;
    @(negedge clk);
    mif.mem_rd         = 1'b1;
    mif.mem_we         = 1'b0;
    mif.mem_addr       = addr;
    mif.mem_burstcount = 8'(bc);
    wait_accept("rd_cmd");
    @(negedge clk);
    k = 0;
    t = 0;
    while (k < n && t < 1000) begin
      n_vec++;
      if (mif.mem_busy !== 1'b1) begin
        n_err++;
        $display("FAIL rd_burst_busy: busy=%b, required 1", mif.mem_busy);
      end
      if (!stall_exp) begin
        exp_q.push_back('{mem_m[idx], cyc + LAT});
        idx = (idx + 1) % DEPTH;
        k++;
      end
      mif.mem_rd   = 1'($urandom);
      mif.mem_we   = 1'($urandom);
      mif.mem_addr = $urandom;
      mif.mem_din  = $urandom;
      mif.mem_be   = 4'($urandom);
      @(negedge clk);
      t++;
    end
    mif.mem_rd = 1'b0;
    mif.mem_we = 1'b0;
    if (k < n) begin
      n_err++;
      $display("FAIL rd_issue_timeout: issued %0d beats, required %0d", k, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec += 3;
    if (mif.mem_dout !== 32'h0) begin
      n_err++; $display("FAIL reset_dout: dout=%h, required 0", mif.mem_dout);
    end
    if (mif.mem_dout_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: ready=%b, required 0", mif.mem_dout_ready);
    end
    if (mif.mem_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: busy=%b, required 0", mif.mem_busy);
    end
    reset = 1'b0;
    idle(3);
  endtask

  task automatic test_single_read();
    logic [31:0] d [8];
    logic [3:0]  b [8];
    foreach (d[i]) begin d[i] = 32'h0; b[i] = 4'hF; end
    d[0] = 32'hDEADBEEF;
    do_write(32'h10, 1, d, b, 0, 1'b0);
    do_read(32'h10, 0);
    wait_drain();
    n_vec++;
    if (last_dout !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_read: dout=%h, required deadbeef", last_dout);
    end
  endtask

  task automatic test_burst();
    logic [31:0] d [8];
    logic [3:0]  b [8];
    foreach (d[i]) begin d[i] = 32'h11111111 * (i + 1); b[i] = 4'hF; end
    do_write(32'h100, 4, d, b, 0, 1'b0);
    do_read(32'h100, 4);
    wait_drain();
    n_vec++;
    if (last_dout !== 32'h44444444) begin
      n_err++; $display("FAIL burst_last: dout=%h, required 44444444", last_dout);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d [8];
    logic [3:0]  b [8];
    foreach (d[i]) begin d[i] = 32'h0; b[i] = 4'hF; end
    d[0] = 32'hAABBCCDD;
    do_write(32'h14, 1, d, b, 0, 1'b0);
    d[0] = 32'h11223344;
    b[0] = 4'b0101;
    do_write(32'h14, 1, d, b, 0, 1'b0);
    do_read(32'h14, 1);
    wait_drain();
    n_vec++;
    if (last_dout !== 32'hAA22CC44) begin
      n_err++; $display("FAIL byte_enable: dout=%h, required aa22cc44", last_dout);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d [8];
    logic [3:0]  b [8];
    foreach (d[i]) begin d[i] = $urandom; b[i] = 4'hF; end
    do_write(32'h3C, 3, d, b, 2, 1'b0);
    do_read(32'h3C, 3);
    wait_drain();
    n_vec++;
    if (last_dout !== d[2]) begin
      n_err++; $display("FAIL wrap_last: dout=%h, required %h", last_dout, d[2]);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d [8];
    logic [3:0]  b [8];
    int          seen0;
    foreach (d[i]) begin d[i] = 32'h0BADF00D; b[i] = 4'hF; end
    do_write(32'h1C, 1, d, b, 0, 1'b0);
    d[0] = 32'h5A5AA5A5;
    seen0 = beats_seen;
    do_write(32'h1C, 1, d, b, 0, 1'b1);
    idle(LAT + 3);
    n_vec++;
    if (beats_seen != seen0) begin
      n_err++; $display("FAIL priority_no_read: %0d beats, required 0", beats_seen - seen0);
    end
    do_read(32'h1C, 1);
    wait_drain();
    n_vec++;
    if (last_dout !== 32'h5A5AA5A5) begin
      n_err++; $display("FAIL priority_write: dout=%h, required 5a5aa5a5", last_dout);
    end
  endtask

  task automatic test_random();
    logic [31:0] d [8];
    logic [3:0]  b [8];
    foreach (d[i]) begin d[i] = $urandom; b[i] = 4'hF; end
    do_write(32'h0, 8, d, b, 0, 1'b0);
    foreach (d[i]) d[i] = $urandom;
    do_write(32'h20, 8, d, b, 0, 1'b0);
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        foreach (d[i]) begin d[i] = $urandom; b[i] = 4'($urandom); end
        do_write($urandom, $urandom_range(0, 8), d, b, 2, 1'b0);
      end else begin
        do_read($urandom, $urandom_range(0, 8));
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    wait_drain();
  endtask

  task automatic test_long_burst();
    logic [31:0] d [8];
    logic [3:0]  b [8];
    int          seen0;
    foreach (d[i]) begin d[i] = $urandom; b[i] = 4'hF; end
    do_write(32'h8, 8, d, b, 1, 1'b0);
    foreach (d[i]) d[i] = $urandom;
    do_write(32'h28, 8, d, b, 1, 1'b0);
    seen0 = beats_seen;
    do_read(32'h24, 16);
    wait_drain();
    n_vec++;
    if (beats_seen - seen0 != 16) begin
      n_err++; $display("FAIL long_burst_count: %0d beats, required 16", beats_seen - seen0);
    end
  endtask

  task automatic test_reset_mid_read();
    int idx, seen0;
    idx = 3;
    @(negedge clk);
    mif.mem_rd         = 1'b1;
    mif.mem_we         = 1'b0;
    mif.mem_addr       = 32'h0C;
    mif.mem_burstcount = 8'd8;
    wait_accept("rst_rd_cmd");
    @(negedge clk);
    mif.mem_rd = 1'b0;
    repeat (2) begin
      n_vec++;
      if (mif.mem_busy !== 1'b1) begin
        n_err++; $display("FAIL rst_rd_busy: busy=%b, required 1", mif.mem_busy);
      end
      if (!stall_exp) begin
        exp_q.push_back('{mem_m[idx], cyc + LAT});
        idx = (idx + 1) % DEPTH;
      end
      @(negedge clk);
    end
    #1;
    reset = 1'b1;
    exp_q.delete();
    last_dout = 32'h0;
    #1;
    n_vec += 3;
    if (mif.mem_dout_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_ready: ready=%b, required 0", mif.mem_dout_ready);
    end
    if (mif.mem_busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_busy: busy=%b, required 0", mif.mem_busy);
    end
    if (mif.mem_dout !== 32'h0) begin
      n_err++; $display("FAIL midrst_dout: dout=%h, required 0", mif.mem_dout);
    end
    seen0 = beats_seen;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(LAT + 8);
    n_vec++;
    if (beats_seen != seen0) begin
      n_err++; $display("FAIL midrst_beats: %0d beats after reset, required 0", beats_seen - seen0);
    end
    do_read(32'h0C, 2);
    wait_drain();
    n_vec++;
    if (last_dout !== mem_m[4]) begin
      n_err++; $display("FAIL post_reset_read: dout=%h, required %h", last_dout, mem_m[4]);
    end
  endtask

  initial begin
    mif.mem_addr       = 32'h0;
    mif.mem_din        = 32'h0;
    mif.mem_be         = 4'h0;
    mif.mem_burstcount = 8'd0;
    mif.mem_rd         = 1'b0;
    mif.mem_we         = 1'b0;
    test_reset();
    test_single_read();
    test_burst();
    test_byte_enable();
    test_wrap();
    test_priority();
    test_random();
    test_long_burst();
    test_reset_mid_read();
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
